// File: rtl/span_pkg.sv
// Shared FSM state type, FIFO word layout and default framebuffer geometry for span_fill.
package span_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RDL,
    CAPL,
    RDR,
    CAPR,
    SETUP,
    FILL,
    DONE
  } state_t;

  localparam int Y_MSB      = 31;
  localparam int X_MSB      = 15;
  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;

  function automatic logic [15:0] word_y(input logic [31:0] w);
    return w[Y_MSB -: 16];
  endfunction

  function automatic logic [15:0] word_x(input logic [31:0] w);
    return w[X_MSB -: 16];
  endfunction

endpackage

// File: rtl/span_addr.sv
// Combinational span geometry: orders the endpoints, optionally clips (SPAN_FILL_CLIP_EN),
// and produces first/last pixel addresses at ADDR_W+1 bits for span_fill to register.
module span_addr
  import span_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 17
) (
  input  logic [15:0]   y,
  input  logic [15:0]   xa,
  input  logic [15:0]   xb,
  output logic [ADDR_W:0] base,
  output logic [ADDR_W:0] last,
  output logic          discard
);

  logic signed [31:0] ys;
  logic signed [31:0] xas;
  logic signed [31:0] xbs;
  logic signed [31:0] lo;
  logic signed [31:0] hi;
  logic signed [31:0] row;

  always_comb begin
    ys      = {{16{y[15]}}, y};
    xas     = {{16{xa[15]}}, xa};
    xbs     = {{16{xb[15]}}, xb};
    lo      = (xas > xbs) ? xbs : xas;
    hi      = (xas > xbs) ? xas : xbs;
    discard = 1'b0;
`ifdef SPAN_FILL_CLIP_EN
    discard = (ys < 0) || (ys >= HEIGHT) || (hi < 0) || (lo >= WIDTH);
    if (lo < 0) lo = 0;
    if (hi > WIDTH - 1) hi = WIDTH - 1;
`endif
    // Only the low ADDR_W+1 bits matter; wrap-around is the producer's concern.
    row  = ys * WIDTH;
    base = (ADDR_W+1)'(row + lo);
    last = (ADDR_W+1)'(row + hi);
  end

endmodule

// File: rtl/span_fill.sv
// Span filler: reads {y,x} endpoint pairs from a FIFO and writes xl..xr of row y, one pixel per accepted cycle.
// First fb_we two cycles after CAPR; fb_we/fb_addr/fb_data hold while fb_ready is low (SPAN_FILL_CLIP_EN enables clipping).
module span_fill
  import span_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd,
  input  logic [31:0]        fifo_data,
  input  logic [COLOR_W-1:0] color,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               busy,
  output logic [15:0]        span_count,
  output logic               pair_err
);

  state_t             state;
  logic               cap_hold;
  logic [15:0]        y_r;
  logic [15:0]        xl_r;
  logic [15:0]        xr_r;
  logic [COLOR_W-1:0] color_r;
  logic [ADDR_W:0]    addr_r;
  logic [ADDR_W:0]    last_r;
  logic [ADDR_W:0]    base;
  logic [ADDR_W:0]    last;
  logic               discard;

  span_addr #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .y       (y_r),
    .xa      (xl_r),
    .xb      (xr_r),
    .base    (base),
    .last    (last),
    .discard (discard)
  );

  assign busy    = (state != IDLE);
  assign fb_addr = addr_r[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_hold   <= 1'b0;
      fifo_rd    <= 1'b0;
      fb_we      <= 1'b0;
      fb_data    <= '0;
      span_count <= '0;
      pair_err   <= 1'b0;
      y_r        <= '0;
      xl_r       <= '0;
      xr_r       <= '0;
      color_r    <= '0;
      addr_r     <= '0;
      last_r     <= '0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd <= 1'b1;
            state   <= RDL;
          end
        end
        RDL: state <= CAPL;
        CAPL: begin
          // Left word stays on fifo_data while we wait for the right one; capture it only once.
          if (!cap_hold) begin
            y_r     <= word_y(fifo_data);
            xl_r    <= word_x(fifo_data);
            color_r <= color;
          end
          if (!fifo_empty) begin
            fifo_rd  <= 1'b1;
            cap_hold <= 1'b0;
            state    <= RDR;
          end else begin
            cap_hold <= 1'b1;
          end
        end
        RDR: state <= CAPR;
        CAPR: begin
          xr_r <= word_x(fifo_data);
          if (word_y(fifo_data) != y_r) pair_err <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          fb_data <= color_r;
          addr_r  <= base;
          last_r  <= last;
          if (discard) begin
            state <= DONE;
          end else begin
            fb_we <= 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          if (fb_ready) begin
            if (addr_r == last_r) begin
              fb_we <= 1'b0;
              state <= DONE;
            end else begin
              addr_r <= addr_r + 1'b1;
            end
          end
        end
        DONE: begin
          span_count <= span_count + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_span_fill.sv
// Bench for span_fill: FIFO and framebuffer models, per-pixel reference built from span endpoints.
module tb_span_fill;

  localparam int WIDTH   = 320;
  localparam int HEIGHT  = 240;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 16;
  localparam int AMASK   = (1 << ADDR_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fifo_empty;
  logic               fifo_rd;
  logic [31:0]        fifo_data = '0;
  logic [COLOR_W-1:0] color = '0;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_ready = 1'b1;
  logic               busy;
  logic [15:0]        span_count;
  logic               pair_err;

  span_fill #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W), .COLOR_W(COLOR_W)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .color(color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
    .busy(busy), .span_count(span_count), .pair_err(pair_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Span FIFO model: data appears the cycle after the read strobe.
  logic [31:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd && (rd_ptr != wr_ptr)) begin
      fifo_data <= fifo_mem[rd_ptr % 4096];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // fb_ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1 over the fill cycles
  int rdy_mode = 0;
  int pat_i    = 0;
  logic [3:0] rdy_pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) fb_ready = 1'b1;
    else if (rdy_mode == 1) fb_ready = 1'($urandom_range(0, 1));
    else if (fb_we) begin
      fb_ready = (pat_i < 4) ? rdy_pat[pat_i] : 1'b1;
      pat_i++;
    end else begin
      fb_ready = 1'b1;
      pat_i    = 0;
    end
  end

  // Bus monitor, sampled mid-cycle.
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int rd_cyc_q[$];
  int rd_bad = 0;
  int stall_seen = 0;
  int stall_bad = 0;
  logic prev_stall = 1'b0;
  logic prev_rd = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [COLOR_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (fifo_rd) begin
      rd_cyc_q.push_back(cyc);
      if (fifo_empty || prev_rd) rd_bad++;
    end
    prev_rd = fifo_rd;
    if (prev_stall) begin
      stall_seen++;
      if (!(fb_we === 1'b1 && fb_addr === prev_addr && fb_data === prev_data)) stall_bad++;
    end
    if (fb_we && fb_ready) begin
      wr_addr_q.push_back(int'(fb_addr));
      wr_data_q.push_back(int'(fb_data));
      wr_cyc_q.push_back(cyc);
    end
    prev_stall = fb_we && !fb_ready;
    prev_addr  = fb_addr;
    prev_data  = fb_data;
  end

  // Reference model: the pixels a span should paint, straight from its endpoints.
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_count = 0;
  logic exp_pair_err = 1'b0;

  function automatic void model_span(input int y0, input int x0, input int y1, input int x1, input int col);
    int lo;
    int hi;
    lo = (x0 < x1) ? x0 : x1;
    hi = (x0 < x1) ? x1 : x0;
    if (y1 != y0) exp_pair_err = 1'b1;
    exp_count++;
`ifdef SPAN_FILL_CLIP_EN
    if (y0 < 0 || y0 >= HEIGHT || hi < 0 || lo >= WIDTH) return;
    if (lo < 0) lo = 0;
    if (hi > WIDTH - 1) hi = WIDTH - 1;
`endif
    for (int x = lo; x <= hi; x++) begin
      exp_addr_q.push_back((y0 * WIDTH + x) & AMASK);
      exp_data_q.push_back(col);
    end
  endfunction

  function automatic int diff_writes();
    int n = 0;
    if (wr_addr_q.size() != exp_addr_q.size()) n++;
    for (int i = 0; i < wr_addr_q.size() && i < exp_addr_q.size(); i++)
      if (wr_addr_q[i] != exp_addr_q[i] || wr_data_q[i] != exp_data_q[i]) n++;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); rd_cyc_q.delete();
    exp_addr_q.delete(); exp_data_q.delete();
    return n;
  endfunction

  task automatic push_word(input int yv, input int xv);
    fifo_mem[wr_ptr % 4096] = {yv[15:0], xv[15:0]};
    wr_ptr++;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (span_count == exp_count[15:0] && !busy && fifo_empty) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_span(input int y0, input int x0, input int y1, input int x1, input int col, output bit to);
    model_span(y0, x0, y1, x1, col);
    color = col[COLOR_W-1:0];
    push_word(y0, x0);
    push_word(y1, x1);
    wait_idle(to);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
    n_checks++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd: got %b want 0", fifo_rd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (span_count !== 16'd0) begin n_fail++; $display("FAIL reset_span_count: got %0d want 0", span_count); end
    n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL reset_pair_err: got %b want 0", pair_err); end
    n_checks++; if (fb_addr !== '0) begin n_fail++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
    n_checks++; if (fb_data !== '0) begin n_fail++; $display("FAIL reset_fb_data: got %0d want 0", fb_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit to;
    int n;
    int lat;
    int spread;
    rdy_mode = 0;
    run_span(5, 10, 5, 13, 16'h1234, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: span did not finish"); end
    n = wr_addr_q.size();
    lat = (rd_cyc_q.size() >= 2 && n > 0) ? wr_cyc_q[0] - rd_cyc_q[1] : -1;
    spread = (n == 4) ? wr_cyc_q[3] - wr_cyc_q[0] : -1;
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL basic_count: got %0d writes want 4", n); end
    n_checks++; if (n == 0 || wr_addr_q[0] != 1610) begin n_fail++; $display("FAIL basic_first_addr: got %0d want 1610", n ? wr_addr_q[0] : -1); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d cycles want 3", lat); end
    n_checks++; if (spread != 3) begin n_fail++; $display("FAIL basic_throughput: got %0d cycles want 3", spread); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL basic_writes: got %0d mismatches want 0", n); end
    n_checks++; if (span_count !== 16'd1) begin n_fail++; $display("FAIL basic_span_count: got %0d want 1", span_count); end
  endtask

  task automatic test_swap();
    bit to;
    int n;
    run_span(2, 20, 2, 17, 16'hBEEF, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL swap_timeout: span did not finish"); end
    n = wr_addr_q.size();
    n_checks++; if (n != 4 || wr_addr_q[0] != 657 || wr_addr_q[3] != 660) begin n_fail++; $display("FAIL swap_range: got %0d writes from %0d want 4 from 657", n, n ? wr_addr_q[0] : -1); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL swap_writes: got %0d mismatches want 0", n); end
    n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL swap_pair_err: got %b want 0", pair_err); end
  endtask

  task automatic test_pair_err();
    bit to;
    int n;
    run_span(7, 4, 8, 4, 16'h00F0, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL pair_timeout: span did not finish"); end
    n = wr_addr_q.size();
    n_checks++; if (n != 1 || wr_addr_q[0] != 2244) begin n_fail++; $display("FAIL pair_single: got %0d writes at %0d want 1 at 2244", n, n ? wr_addr_q[0] : -1); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL pair_writes: got %0d mismatches want 0", n); end
    n_checks++; if (pair_err !== 1'b1) begin n_fail++; $display("FAIL pair_err_set: got %b want 1", pair_err); end
  endtask

  task automatic test_stall();
    bit to;
    int n;
    int s0;
    s0 = stall_seen;
    rdy_mode = 2;
    run_span(0, 0, 0, 2, 16'h0A0A, to);
    rdy_mode = 0;
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: span did not finish"); end
    n_checks++; if (stall_seen - s0 != 2) begin n_fail++; $display("FAIL stall_cycles: got %0d stalled cycles want 2", stall_seen - s0); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL stall_writes: got %0d mismatches want 0", n); end
    n_checks++; if (pair_err !== 1'b1) begin n_fail++; $display("FAIL pair_err_sticky: got %b want 1", pair_err); end
  endtask

  task automatic test_clip();
    bit to;
    int n;
    int first;
    int c0;
    c0 = exp_count;
    run_span(3, -5, 3, 2, 16'h7777, to);
    n = wr_addr_q.size();
    first = n ? wr_addr_q[0] : -1;
`ifdef SPAN_FILL_CLIP_EN
    n_checks++; if (n != 3 || first != 960) begin n_fail++; $display("FAIL clip_left: got %0d writes from %0d want 3 from 960", n, first); end
`else
    n_checks++; if (n != 8 || first != 955) begin n_fail++; $display("FAIL raw_left: got %0d writes from %0d want 8 from 955", n, first); end
`endif
    n = diff_writes();
    n_checks++; if (n != 0 || to) begin n_fail++; $display("FAIL clip_left_writes: got %0d mismatches timeout %0d want 0", n, to); end
    run_span(300, 1, 300, 4, 16'h5555, to);
    n = diff_writes();
    n_checks++; if (n != 0 || to) begin n_fail++; $display("FAIL clip_row_writes: got %0d mismatches timeout %0d want 0", n, to); end
    n_checks++; if (span_count !== 16'(c0 + 2)) begin n_fail++; $display("FAIL clip_span_count: got %0d want %0d", span_count, c0 + 2); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    int tot;
    int gap1;
    int col;
    col = int'($urandom_range(0, 65535));
    color = col[COLOR_W-1:0];
    for (int s = 0; s < 6; s++) begin
      int y0;
      int x0;
      int x1;
      y0 = int'($urandom_range(0, HEIGHT - 1));
      x0 = int'($urandom_range(0, WIDTH - 1));
      x1 = int'($urandom_range(0, WIDTH - 1));
      if (x1 > x0 + 20) x1 = x0 + 20;
      model_span(y0, x0, y0, x1, col);
      push_word(y0, x0);
      push_word(y0, x1);
    end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_timeout: spans did not finish"); end
    tot = wr_cyc_q.size();
    gap1 = 0;
    for (int i = 1; i < tot; i++) if (wr_cyc_q[i] - wr_cyc_q[i-1] == 1) gap1++;
    n_checks++; if (gap1 != tot - 6) begin n_fail++; $display("FAIL b2b_rate: got %0d back-to-back writes want %0d", gap1, tot - 6); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL b2b_writes: got %0d mismatches want 0", n); end
    n_checks++; if (span_count !== exp_count[15:0]) begin n_fail++; $display("FAIL b2b_span_count: got %0d want %0d", span_count, exp_count); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    int tos;
    tos = 0;
    rdy_mode = 1;
    for (int s = 0; s < 40; s++) begin
      int y0;
      int y1;
      int x0;
      int x1;
      y0 = int'($urandom_range(0, HEIGHT + 9)) - 5;
      x0 = int'($urandom_range(0, WIDTH + 39)) - 20;
      x1 = x0 + int'($urandom_range(0, 60)) - 30;
      y1 = ($urandom_range(0, 7) == 0) ? y0 + 1 : y0;
      run_span(y0, x0, y1, x1, int'($urandom_range(0, 65535)), to);
      if (to) tos++;
    end
    rdy_mode = 0;
    n_checks++; if (tos != 0) begin n_fail++; $display("FAIL rand_timeout: got %0d stuck spans want 0", tos); end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL rand_writes: got %0d mismatches want 0", n); end
    n_checks++; if (span_count !== exp_count[15:0]) begin n_fail++; $display("FAIL rand_span_count: got %0d want %0d", span_count, exp_count); end
    n_checks++; if (pair_err !== exp_pair_err) begin n_fail++; $display("FAIL rand_pair_err: got %b want %b", pair_err, exp_pair_err); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL rand_stall_hold: got %0d unstable cycles want 0", stall_bad); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    int n;
    rdy_mode = 0;
    color = 16'h3C3C;
    push_word(1, 0);
    push_word(1, 9);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (fb_we) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_start: got no fill want fb_we"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL midrst_fb_we: got %b want 0", fb_we); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (span_count !== 16'd0) begin n_fail++; $display("FAIL midrst_span_count: got %0d want 0", span_count); end
    n_checks++; if (pair_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pair_err: got %b want 0", pair_err); end
    repeat (20) @(posedge clk);
    for (int x = 0; x < 3; x++) begin
      exp_addr_q.push_back(WIDTH + x);
      exp_data_q.push_back(16'h3C3C);
    end
    n = diff_writes();
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL midrst_writes: got %0d mismatches want 0", n); end
    exp_count = 0;
    exp_pair_err = 1'b0;
    run_span(5, 10, 5, 13, 16'h0101, to);
    n = diff_writes();
    n_checks++; if (n != 0 || to) begin n_fail++; $display("FAIL midrst_recover: got %0d mismatches timeout %0d want 0", n, to); end
    n_checks++; if (span_count !== 16'd1) begin n_fail++; $display("FAIL midrst_recount: got %0d want 1", span_count); end
    n_checks++; if (rd_bad != 0) begin n_fail++; $display("FAIL fifo_rd_protocol: got %0d bad strobes want 0", rd_bad); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_pair_err();
    test_stall();
    test_clip();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/span_fill.md
SPAN_FILL -- requirements
Module: span_fill

Interface
REQ-001 Parameter WIDTH, default 320, framebuffer row length in pixels.
REQ-002 Parameter HEIGHT, default 240, framebuffer row count.
REQ-003 Parameter ADDR_W, default 17, framebuffer address width.
REQ-004 Parameter COLOR_W, default 16, pixel data width.
REQ-005 clk  input  1  the only clock; every register is updated on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 fifo_empty  input  1  high when the span FIFO holds no words.
REQ-008 fifo_rd  output  1  one-cycle read strobe to the span FIFO.
REQ-009 fifo_data  input  32  FIFO word {y[15:0], x[15:0]}, both signed; valid the cycle after the fifo_rd strobe.
REQ-010 color  input  COLOR_W  fill colour, sampled when the left word is captured.
REQ-011 fb_we  output  1  framebuffer write request.
REQ-012 fb_addr  output  ADDR_W  framebuffer pixel address.
REQ-013 fb_data  output  COLOR_W  framebuffer pixel value.
REQ-014 fb_ready  input  1  framebuffer accepts the write on any edge where fb_we && fb_ready.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 span_count  output  16  number of completed spans; wraps 0xFFFF->0.
REQ-017 pair_err  output  1  sticky; set when the left and right y of a pair differ.

Function
REQ-018 FIFO words arrive in pairs: left endpoint, then right endpoint, of one scanline span.
REQ-019 The FSM SHALL use these transitions:
- IDLE->RDL when !fifo_empty, asserting fifo_rd.
- RDL->CAPL.
- CAPL->RDR when !fifo_empty, asserting fifo_rd; otherwise it stays in CAPL.
- RDR->CAPR.
- CAPR->SETUP.
- SETUP->FILL, or SETUP->DONE if the span is discarded.
- FILL->DONE on acceptance of the last pixel.
- DONE->IDLE.
REQ-020 fifo_rd SHALL never be asserted while fifo_empty is high, and SHALL never be high for 2 consecutive cycles.
REQ-021 CAPL SHALL latch xl, y and color; CAPR SHALL latch xr.
REQ-022 If the captured xl > xr (signed comparison), the two values SHALL be swapped.
REQ-023 If the right y differs from the left y, the left y SHALL be used and pair_err SHALL be set.
REQ-024 SETUP SHALL compute base = y*WIDTH + xl once; FILL SHALL increment the address by 1 per accepted write, with no multiply per pixel.
REQ-025 The first fb_we SHALL be asserted in the cycle after SETUP, i.e. 2 cycles after CAPR.
REQ-026 The span SHALL write pixels xl..xr inclusive; a span with xl == xr produces exactly 1 write.
REQ-027 While fb_we && !fb_ready, fb_we, fb_addr and fb_data SHALL hold stable.
REQ-028 With fb_ready held high, FILL SHALL sustain 1 pixel per cycle.
REQ-029 DONE SHALL increment span_count by 1, including for discarded spans.
REQ-030 Address arithmetic SHALL be done at ADDR_W+1 bits and truncated to ADDR_W on output.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL enter IDLE and set fb_we=0, fifo_rd=0, busy=0, span_count=0, pair_err=0, fb_addr=0 and fb_data=0.
REQ-032 A reset asserted mid-span SHALL abandon the span with no further fb_we; the FIFO contents are not drained.

Configuration
REQ-033 Macro SPAN_FILL_CLIP_EN selects clipping behaviour.
- Defined: a span with y<0, y>=HEIGHT, xr<0 or xl>=WIDTH SHALL be discarded with zero writes; otherwise xl and xr SHALL be clamped to [0, WIDTH-1] in SETUP.
- Undefined: raw coordinates SHALL be used, and out-of-range addresses are the producer's responsibility.

Structure
REQ-034 Shared package span_pkg SHALL hold the FSM state enum, the pixel word field offsets (Y_MSB=31, X_MSB=15) and default WIDTH/HEIGHT constants.
REQ-035 Sub-module span_addr SHALL compute base = y*WIDTH + x and the clamp logic; it is purely combinational and registered by span_fill.

Verification
REQ-036 FIFO words {5,10},{5,13}, fb_ready=1 -> writes to addr 1610..1613 on 4 consecutive cycles; span_count=1.
REQ-037 Words {2,20},{2,17} -> swap applied; addrs 657..660 written; pair_err=0.
REQ-038 Words {7,4},{8,4} -> exactly 1 write at addr 2244; pair_err=1 and remains 1 afterwards.
REQ-039 fb_ready toggles 1,0,0,1 during span {0,0},{0,2} -> each addr 0,1,2 is accepted exactly once; fb_addr/fb_data are stable while stalled.
REQ-040 With SPAN_FILL_CLIP_EN defined: {3,-5},{3,2} -> addrs 960..962; {300,1},{300,4} -> 0 writes, span_count still increments.
REQ-041 rst pulsed on the 3rd FILL cycle of span {1,0},{1,9} -> fb_we low on the next cycle; busy=0; span_count=0.
